sound_tone_player: RTL and testbench

- Consumer end of the game controller's sound request interface (`enable_sound`, `sound_freq`).
- Turns a short request into a fixed-length square-wave tone, using a phase-accumulator (NCO) oscillator and a duration timer.
- Drives a 1-bit square output for a piezo/GPIO pin and a signed 16-bit sample for the audio codec path.
- Reports `busy` status and a one-cycle `done` strobe back to game logic.

---
 rtl/sound_tone_player.sv | 116 +++++++++++
 tb/tb_sound_tone_player.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sound_tone_player.sv
// sound_tone_player: fixed-length square-wave tone generator driven by the
// game controller's sound request. A phase accumulator (NCO) sets the pitch
// and a down-counter sets the tone length. The block drives a 1-bit square
// output, a signed 16-bit sample, a busy flag and a one-cycle done strobe.
module sound_tone_player #(
  parameter int unsigned        ACC_W           = 32,
  parameter int unsigned        INC_PER_HZ      = 172,
  parameter int unsigned        DURATION_CYCLES = 12500000,
  parameter logic signed [15:0] AMPLITUDE       = 16'sd8000
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               enable_sound,
  input  logic [9:0]         sound_freq,
  input  logic               mute,
  output logic               audio_square,
  output logic signed [15:0] audio_sample,
  output logic               busy,
  output logic               done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  localparam int unsigned CNT_W = (DURATION_CYCLES > 1) ? $clog2(DURATION_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DURATION_CYCLES - 1);
  localparam logic [ACC_W-1:0] INC_W    = ACC_W'(INC_PER_HZ);

  logic [0:0]         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [9:0]         freq_q, freq_d;
  logic               enable_q;
  logic               done_q, done_d;
  logic               square_q, square_d;
  logic signed [15:0] sample_q, sample_d;

  logic               req;
  logic               valid_req;
  logic               playing_d;
  logic [ACC_W-1:0]   inc;

  // Phase step for the latched frequency, truncated to the accumulator width.
  always_comb begin
    inc = ACC_W'(freq_q) * INC_W;
  end

  // Next-state logic: request detection, tone start/retrigger, expiry.
  always_comb begin
    req       = enable_sound & ~enable_q;
    valid_req = req & (sound_freq != '0);
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    freq_d    = freq_q;
    if (valid_req) begin
      // A fresh request restarts the tone even on the expiry cycle.
      state_d = ST_PLAY;
      freq_d  = sound_freq;
      acc_d   = '0;
      cnt_d   = CNT_LOAD;
    end else if (state_q == ST_PLAY) begin
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
        acc_d   = '0;
      end else begin
        acc_d = acc_q + inc;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Output values computed from next state so the registered outputs line up
  // with the state/accumulator registers they are derived from.
  always_comb begin
    playing_d = (state_d == ST_PLAY);
    done_d    = (state_q == ST_PLAY) && (state_d == ST_IDLE);
    square_d  = playing_d & ~mute & acc_d[ACC_W-1];
    if (square_d) begin
      sample_d = AMPLITUDE;
    end else if (playing_d && !mute) begin
      sample_d = -AMPLITUDE;
    end else begin
      sample_d = '0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      freq_q   <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      square_q <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      freq_q   <= freq_d;
      enable_q <= enable_sound;
      done_q   <= done_d;
      square_q <= square_d;
      sample_q <= sample_d;
    end
  end

  assign audio_square = square_q;
  assign audio_sample = sample_q;
  assign busy         = (state_q == ST_PLAY);
  assign done         = done_q;

endmodule

// File: tb/tb_sound_tone_player.sv
// Testbench for sound_tone_player: directed test-plan steps plus random
// request/mute/frequency traffic, checked every cycle against an elapsed-time
// model of the tone (phase = freq*INC*elapsed mod 2^ACC_W).
module tb_sound_tone_player;

  localparam int unsigned ACC_W = 16;
  localparam int unsigned INC   = 1;
  localparam int unsigned DUR   = 1000;
  localparam int          AMP   = 100;

  logic               clk = 1'b0;
  logic               resetN;
  logic               enable_sound;
  logic [9:0]         sound_freq;
  logic               mute;
  logic               audio_square;
  logic signed [15:0] audio_sample;
  logic               busy;
  logic               done;

  int errors = 0;
  int checks = 0;

  // Model state: whether a tone plays, cycles since it started, its frequency.
  bit      m_play;
  int      m_k;
  int      m_freq;
  bit      m_prev_en;
  bit      m_done;
  bit      m_sq;
  int      m_samp;

  int      n_done;
  int      n_busy;

  sound_tone_player #(
    .ACC_W          (ACC_W),
    .INC_PER_HZ     (INC),
    .DURATION_CYCLES(DUR),
    .AMPLITUDE      (16'sd100)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .enable_sound(enable_sound),
    .sound_freq  (sound_freq),
    .mute        (mute),
    .audio_square(audio_square),
    .audio_sample(audio_sample),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_play = 0; m_k = 0; m_freq = 0; m_prev_en = 0;
    m_done = 0; m_sq = 0; m_samp = 0;
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge();
    bit     req;
    longint phase;
    if (!resetN) begin
      model_reset();
      return;
    end
    req       = enable_sound && !m_prev_en;
    m_prev_en = enable_sound;
    m_done    = 0;
    if (req && sound_freq != 0) begin
      m_play = 1; m_k = 0; m_freq = int'(sound_freq);
    end else if (m_play) begin
      if (m_k == int'(DUR) - 1) begin
        m_play = 0; m_done = 1;
      end else begin
        m_k++;
      end
    end
    phase  = (longint'(m_freq) * INC * m_k) % (longint'(1) << ACC_W);
    m_sq   = m_play && !mute && (phase >= (longint'(1) << (ACC_W - 1)));
    m_samp = (!m_play || mute) ? 0 : (m_sq ? AMP : -AMP);
  endtask

  task automatic check_outputs();
    chk("busy",   busy,         m_play);
    chk("done",   done,         m_done);
    chk("square", audio_square, m_sq);
    chk("sample", audio_sample, m_samp);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    n_done += int'(done);
    n_busy += int'(busy);
  endtask

  // Run n cycles with enable held; frequency wanders to show it is ignored.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sound_freq = 10'($urandom_range(0, 1023));
      step();
    end
  endtask

  task automatic pulse(input int f);
    enable_sound = 1'b1;
    sound_freq   = 10'(f);
    step();
    enable_sound = 1'b0;
  endtask

  task automatic clear_stats();
    n_done = 0;
    n_busy = 0;
  endtask

  initial begin
    resetN = 1'b0; enable_sound = 1'b0; sound_freq = '0; mute = 1'b0;
    model_reset();
    clear_stats();

    // Reset and idle.
    step(); step(); step();
    resetN = 1'b1;
    clear_stats();
    run(50);
    chk("idle_busy_count", n_busy, 0);

    // Basic tone.
    clear_stats();
    pulse(256);
    run(1100);
    chk("basic_busy_len", n_busy, 1000);
    chk("basic_done_cnt", n_done, 1);

    // Held request: exactly one tone.
    clear_stats();
    enable_sound = 1'b1; sound_freq = 10'd512;
    step();
    run(2999);
    enable_sound = 1'b0;
    run(50);
    chk("held_busy_len", n_busy, 1000);
    chk("held_done_cnt", n_done, 1);

    // Zero frequency is ignored.
    clear_stats();
    pulse(0);
    run(20);
    chk("freq0_busy", n_busy, 0);

    // Retrigger at cycle 600.
    clear_stats();
    pulse(256);
    run(599);
    pulse(128);
    run(1100);
    chk("retrig_busy_len", n_busy, 1600);
    chk("retrig_done_cnt", n_done, 1);

    // Retrigger exactly on the last (counter==0) cycle.
    clear_stats();
    pulse(300);
    run(999);
    chk("last_cycle_busy", busy, 1);
    pulse(77);
    run(1100);
    chk("edge_retrig_busy", n_busy, 2000);
    chk("edge_retrig_done", n_done, 1);

    // Mute window 200..400.
    clear_stats();
    pulse(200);
    run(199);
    mute = 1'b1;
    run(201);
    mute = 1'b0;
    run(700);
    chk("mute_busy_len", n_busy, 1000);
    chk("mute_done_cnt", n_done, 1);

    // Reset mid-tone at cycle 300.
    clear_stats();
    pulse(256);
    run(299);
    resetN = 1'b0;
    model_reset();
    #1;
    check_outputs();
    step(); step(); step();
    resetN = 1'b1;
    run(10);
    chk("rst_mid_done", n_done, 0);
    clear_stats();
    pulse(256);
    run(1100);
    chk("rst_after_busy", n_busy, 1000);
    chk("rst_after_done", n_done, 1);

    // Random requests, frequencies and mute.
    for (int i = 0; i < 4000; i++) begin
      enable_sound = ($urandom_range(0, 249) == 0);
      sound_freq   = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 99) == 0) mute = ~mute;
      step();
    end
    enable_sound = 1'b0; mute = 1'b0;
    run(1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
